decode_execute_reg: RTL and testbench
=====================================

// Module: decode_execute_reg
// PURPOSE
//  Decode->execute pipeline register of the Y86 core. Latches decoded instruction fields into the execute stage.
//  Keeps a 2-deep history of destination registers and registers the forwarding-select flags consumed by the
//  execute-stage forwarding mux. Detects load-use hazards, stalls decode and inserts a bubble.
// PARAMETERS
//  WIDTH       32     datapath width of valA/valB/valC/valP
//  RNONE       4'hF   "no register" encoding
//  ICODE_NOP   4'h1   icode loaded on a bubble
//  CNT_W       16     width of load-use stall counter
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous reset, active-low
//  d_valid       in   1      decode stage holds a real instruction
//  d_icode/d_ifun in  4/4    decoded opcode/function
//  d_regA/d_regB in   4/4    source registers (RNONE = unused)
//  d_valA/d_valB in   WIDTH  register-file read values
//  d_valC/d_valP in   WIDTH  immediate / next PC
//  d_dstE/d_dstM in   4/4    ALU-result / memory-load destination
//  ext_stall     in   1      downstream stall: hold everything
//  ext_flush     in   1      mispredict: load bubble
//  e_valid       out  1      execute stage holds a real instruction
//  e_icode,e_ifun,e_regA,e_regB,e_dstE,e_dstM  out 4 each  latched fields
//  e_valA,e_valB,e_valC,e_valP                 out WIDTH   latched values
//  applyEx2Fwd   out  1      source matches dstE of instruction one ahead
//  applyMemFwd   out  2      [1]: match dstE two ahead; [0]: match dstM two ahead
//  d_stall       out  1      combinational; hold fetch/decode this cycle
//  lu_count      out  CNT_W  load-use bubbles inserted, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - e_valid=0, e_icode=ICODE_NOP, e_ifun=0, e_reg*/e_dst*=RNONE, e_val*=0.
//   - applyEx2Fwd=0, applyMemFwd=0, history invalid, lu_count=0.
//  History: hist0 = {valid,dstE,dstM} of the instruction that most recently left execute.
//  Load-use:
//   - lu = d_valid & e_valid & (e_icode==5 | e_icode==4'hB) & e_dstM!=RNONE & (e_dstM==d_regA | e_dstM==d_regB).
//   - d_stall = lu & ~ext_flush & ~ext_stall, or ext_stall.
//  Per-edge priority: ext_stall > ext_flush > lu > capture.
//   - ext_stall: all registers hold, including history and flags.
//   - ext_flush: load bubble (reset-like fields, e_valid=0, flags=0). History still shifts.
//   - lu: load bubble, shift history, lu_count+1 (stick at all-ones).
//   - capture: e_* <= d_*, e_valid <= d_valid, shift history.
//  History shift: hist0 <= {e_valid,e_dstE,e_dstM}.
//  Flags, registered with capture; m(r) = r!=RNONE & (r==d_regA | r==d_regB):
//   - applyEx2Fwd <= d_valid & e_valid & m(e_dstE)
//   - applyMemFwd[1] <= d_valid & hist0.valid & m(hist0.dstE)
//   - applyMemFwd[0] <= d_valid & hist0.valid & m(hist0.dstM)
//   - Flags are 0 on any bubble. RNONE never matches, even if both fields are RNONE.
//  Latency: 1 cycle d_* -> e_*. No combinational path d_* -> e_*. d_stall is combinational from e_* and d_reg*.
//  A bubble invalidates its own history entry, so a load's dstM ages out after 2 shifts.
//  Reset mid-stall returns to the reset state immediately. The counter is not cleared by flush.
// TESTING
//  1. Reset, then capture irmovl (icode 3) with dstE=2.
//     -> e_* equal inputs next edge, e_valid=1, flags 0.
//  2. addl (srcA=2) directly after irmovl dstE=2 -> applyEx2Fwd=1, applyMemFwd=0.
//     With one nop between them -> applyMemFwd=2'b10.
//  3. mrmovl (icode 5) dstM=3, followed by addl srcB=3:
//     -> d_stall=1 for 1 cycle, bubble in execute, lu_count=1.
//     -> Then addl enters with applyMemFwd=2'b01, applyEx2Fwd=0.
//  4. ext_stall held 3 cycles with changing d_* -> all e_*, flags, lu_count unchanged.
//     Coincident lu is not counted.
//  5. ext_flush together with a load-use condition -> bubble, lu_count unchanged, d_stall=0.
//  6. Force lu_count to all-ones, trigger a load-use -> lu_count stays all-ones.
//     Assert rst_n=0 mid-sequence -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/decode_execute_reg.sv
// Decode->execute pipeline register for the Y86 core.
// Latches decoded fields into execute. Keeps the destination history used by the
// forwarding flags. Turns a load-use hazard into a decode stall plus an execute bubble.
module decode_execute_reg #(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] RNONE     = 4'hF,
    parameter logic [3:0] ICODE_NOP = 4'h1,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [3:0]       d_regA,
    input  logic [3:0]       d_regB,
    input  logic [WIDTH-1:0] d_valA,
    input  logic [WIDTH-1:0] d_valB,
    input  logic [WIDTH-1:0] d_valC,
    input  logic [WIDTH-1:0] d_valP,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic             ext_stall,
    input  logic             ext_flush,
    output logic             e_valid,
    output logic [3:0]       e_icode,
    output logic [3:0]       e_ifun,
    output logic [3:0]       e_regA,
    output logic [3:0]       e_regB,
    output logic [3:0]       e_dstE,
    output logic [3:0]       e_dstM,
    output logic [WIDTH-1:0] e_valA,
    output logic [WIDTH-1:0] e_valB,
    output logic [WIDTH-1:0] e_valC,
    output logic [WIDTH-1:0] e_valP,
    output logic             applyEx2Fwd,
    output logic [1:0]       applyMemFwd,
    output logic             d_stall,
    output logic [CNT_W-1:0] lu_count
);

    // Destination info of the instruction that most recently left execute.
    logic       hist0Valid;
    logic [3:0] hist0DstE;
    logic [3:0] hist0DstM;

    logic loadUse;
    logic bubble;

    // A real register that is read by either source of decode. RNONE never matches.
    function automatic logic regMatch(input logic [3:0] r, input logic [3:0] a,
                                      input logic [3:0] b);
        return (r != RNONE) && ((r == a) || (r == b));
    endfunction

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Hazard detection and decode stall, purely from execute contents and decode sources.
    always_comb begin
        loadUse = d_valid & e_valid & ((e_icode == 4'h5) | (e_icode == 4'hB))
                  & regMatch(e_dstM, d_regA, d_regB);
        bubble  = ext_flush | loadUse;
        d_stall = ext_stall | (loadUse & ~ext_flush);
    end

    // Execute-stage fields: hold on stall, bubble on flush/load-use, else capture decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= 1'b0;
            e_icode <= ICODE_NOP;
            e_ifun  <= 4'h0;
            e_regA  <= RNONE;
            e_regB  <= RNONE;
            e_dstE  <= RNONE;
            e_dstM  <= RNONE;
            e_valA  <= '0;
            e_valB  <= '0;
            e_valC  <= '0;
            e_valP  <= '0;
        end else if (!ext_stall) begin
            e_valid <= d_valid & ~bubble;
            e_icode <= bubble ? ICODE_NOP : d_icode;
            e_ifun  <= bubble ? 4'h0 : d_ifun;
            e_regA  <= bubble ? RNONE : d_regA;
            e_regB  <= bubble ? RNONE : d_regB;
            e_dstE  <= bubble ? RNONE : d_dstE;
            e_dstM  <= bubble ? RNONE : d_dstM;
            e_valA  <= bubble ? '0 : d_valA;
            e_valB  <= bubble ? '0 : d_valB;
            e_valC  <= bubble ? '0 : d_valC;
            e_valP  <= bubble ? '0 : d_valP;
        end
    end

    // History shifts on every non-stalled edge, bubbles included, so stale loads age out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0Valid <= 1'b0;
            hist0DstE  <= RNONE;
            hist0DstM  <= RNONE;
        end else if (!ext_stall) begin
            hist0Valid <= e_valid;
            hist0DstE  <= e_dstE;
            hist0DstM  <= e_dstM;
        end
    end

    // Forwarding selects travel with the captured instruction; a bubble carries none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            applyEx2Fwd <= 1'b0;
            applyMemFwd <= 2'b00;
        end else if (!ext_stall) begin
            applyEx2Fwd    <= ~bubble & d_valid & e_valid & regMatch(e_dstE, d_regA, d_regB);
            applyMemFwd[1] <= ~bubble & d_valid & hist0Valid & regMatch(hist0DstE, d_regA, d_regB);
            applyMemFwd[0] <= ~bubble & d_valid & hist0Valid & regMatch(hist0DstM, d_regA, d_regB);
        end
    end

    // Count bubbles that were actually inserted for load-use; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_count <= '0;
        end else if (!ext_stall && !ext_flush && loadUse) begin
            lu_count <= satInc(lu_count);
        end
    end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Bench for decode_execute_reg: directed Y86 sequences followed by random traffic,
// every cycle compared against a behavioural pipeline model.
module tb_decode_execute_reg;

    localparam int         WIDTH = 32;
    localparam int         CNT_W = 4;
    localparam int         CMAX  = 15;
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] NOP   = 4'h1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             d_valid;
    logic [3:0]       d_icode, d_ifun, d_regA, d_regB, d_dstE, d_dstM;
    logic [WIDTH-1:0] d_valA, d_valB, d_valC, d_valP;
    logic             ext_stall, ext_flush;
    logic             e_valid;
    logic [3:0]       e_icode, e_ifun, e_regA, e_regB, e_dstE, e_dstM;
    logic [WIDTH-1:0] e_valA, e_valB, e_valC, e_valP;
    logic             applyEx2Fwd;
    logic [1:0]       applyMemFwd;
    logic             d_stall;
    logic [CNT_W-1:0] lu_count;

    decode_execute_reg #(.WIDTH(WIDTH), .RNONE(RNONE), .ICODE_NOP(NOP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_regA(d_regA), .d_regB(d_regB), .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
        .d_valP(d_valP), .d_dstE(d_dstE), .d_dstM(d_dstM), .ext_stall(ext_stall),
        .ext_flush(ext_flush), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
        .e_regA(e_regA), .e_regB(e_regB), .e_dstE(e_dstE), .e_dstM(e_dstM), .e_valA(e_valA),
        .e_valB(e_valB), .e_valC(e_valC), .e_valP(e_valP), .applyEx2Fwd(applyEx2Fwd),
        .applyMemFwd(applyMemFwd), .d_stall(d_stall), .lu_count(lu_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             valid;
        logic [3:0]       icode, ifun, regA, regB, dstE, dstM;
        logic [WIDTH-1:0] valA, valB, valC, valP;
    } instr_t;

    // Model state: the instruction in execute, the instructions that left it (newest first),
    // the flags issued with the execute instruction and the load-use tally.
    instr_t mExec;
    instr_t retired[$];
    logic   mEx2;
    logic [1:0] mMem;
    int     mCount;

    int nTests = 0;
    int nFail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t bubbleInstr();
        instr_t b;
        b = '0;
        b.icode = NOP;
        b.regA = RNONE; b.regB = RNONE; b.dstE = RNONE; b.dstM = RNONE;
        return b;
    endfunction

    function automatic instr_t decodeInstr();
        instr_t d;
        d.valid = d_valid; d.icode = d_icode; d.ifun = d_ifun;
        d.regA = d_regA; d.regB = d_regB; d.dstE = d_dstE; d.dstM = d_dstM;
        d.valA = d_valA; d.valB = d_valB; d.valC = d_valC; d.valP = d_valP;
        return d;
    endfunction

    // Does decode read register r (a real register)?
    function automatic bit reads(input logic [3:0] r);
        return (r != RNONE) && (r == d_regA || r == d_regB);
    endfunction

    function automatic bit modelLoadUse();
        return d_valid && mExec.valid && (mExec.icode == 4'h5 || mExec.icode == 4'hB)
               && reads(mExec.dstM);
    endfunction

    function automatic bit modelStall();
        return ext_stall || (modelLoadUse() && !ext_flush);
    endfunction

    task automatic modelReset();
        mExec = bubbleInstr();
        retired.delete();
        mEx2 = 1'b0;
        mMem = 2'b00;
        mCount = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic modelStep();
        instr_t older;
        instr_t d;
        bit lu;
        older = (retired.size() > 0) ? retired[0] : bubbleInstr();
        lu = modelLoadUse();
        if (ext_stall) return;
        if (ext_flush || lu) begin
            if (!ext_flush) mCount = (mCount >= CMAX) ? CMAX : mCount + 1;
            mEx2 = 1'b0;
            mMem = 2'b00;
            d = bubbleInstr();
        end else begin
            d = decodeInstr();
            mEx2    = d_valid && mExec.valid && reads(mExec.dstE);
            mMem[1] = d_valid && older.valid && reads(older.dstE);
            mMem[0] = d_valid && older.valid && reads(older.dstM);
        end
        retired.push_front(mExec);
        if (retired.size() > 2) void'(retired.pop_back());
        mExec = d;
    endtask

    task automatic checkAll(input string tag);
        chk({tag, ".e_valid"}, e_valid, mExec.valid);
        chk({tag, ".e_icode"}, e_icode, mExec.icode);
        chk({tag, ".e_ifun"},  e_ifun,  mExec.ifun);
        chk({tag, ".e_regA"},  e_regA,  mExec.regA);
        chk({tag, ".e_regB"},  e_regB,  mExec.regB);
        chk({tag, ".e_dstE"},  e_dstE,  mExec.dstE);
        chk({tag, ".e_dstM"},  e_dstM,  mExec.dstM);
        chk({tag, ".e_valA"},  e_valA,  mExec.valA);
        chk({tag, ".e_valB"},  e_valB,  mExec.valB);
        chk({tag, ".e_valC"},  e_valC,  mExec.valC);
        chk({tag, ".e_valP"},  e_valP,  mExec.valP);
        chk({tag, ".ex2"},     applyEx2Fwd, mEx2);
        chk({tag, ".mem"},     applyMemFwd, mMem);
        chk({tag, ".lu_count"}, lu_count, mCount);
    endtask

    task automatic setD(input logic v, input logic [3:0] ic, input logic [3:0] rA,
                        input logic [3:0] rB, input logic [3:0] dE, input logic [3:0] dM);
        d_valid = v; d_icode = ic; d_ifun = 4'($urandom_range(0, 6));
        d_regA = rA; d_regB = rB; d_dstE = dE; d_dstM = dM;
        d_valA = $urandom; d_valB = $urandom; d_valC = $urandom; d_valP = $urandom;
    endtask

    // One clock: check the combinational stall, then the registered outputs after the edge.
    task automatic cycle(input string tag);
        #1;
        chk({tag, ".d_stall"}, d_stall, modelStall());
        modelStep();
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    function automatic logic [3:0] randReg();
        return ($urandom_range(0, 4) == 4) ? RNONE : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] icodes [7];
        icodes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'hB};
        ext_stall = 1'b0;
        ext_flush = 1'b0;
        setD(1'b0, 4'h0, RNONE, RNONE, RNONE, RNONE);

        // Reset state
        #12;
        modelReset();
        checkAll("reset");
        chk("reset.icode_const", e_icode, NOP);
        rst_n = 1'b1;

        // 1: irmovl into r2
        setD(1'b1, 4'h3, RNONE, 4'h2, 4'h2, RNONE);
        cycle("t1");
        chk("t1.valid_const", e_valid, 1'b1);
        chk("t1.icode_const", e_icode, 4'h3);
        chk("t1.flags_const", {applyEx2Fwd, applyMemFwd}, 3'b000);

        // 2: dependent addl right behind, then with a nop in between
        setD(1'b1, 4'h6, 4'h2, 4'h4, 4'h4, RNONE);
        cycle("t2a");
        chk("t2a.ex2_const", applyEx2Fwd, 1'b1);
        chk("t2a.mem_const", applyMemFwd, 2'b00);
        setD(1'b1, 4'h3, RNONE, 4'h2, 4'h2, RNONE);
        cycle("t2b");
        setD(1'b1, NOP, RNONE, RNONE, RNONE, RNONE);
        cycle("t2c");
        setD(1'b1, 4'h6, 4'h2, 4'h4, 4'h4, RNONE);
        cycle("t2d");
        chk("t2d.ex2_const", applyEx2Fwd, 1'b0);
        chk("t2d.mem_const", applyMemFwd, 2'b10);

        // 3: mrmovl into r3, addl reading r3 -> one bubble, then memory forwarding
        setD(1'b1, 4'h5, RNONE, RNONE, RNONE, 4'h3);
        cycle("t3a");
        setD(1'b1, 4'h6, 4'h1, 4'h3, 4'h3, RNONE);
        #1;
        chk("t3.stall_const", d_stall, 1'b1);
        cycle("t3b");
        chk("t3b.valid_const", e_valid, 1'b0);
        chk("t3b.lu_const", lu_count, 4'd1);
        chk("t3.unstall_const", d_stall, 1'b0);
        cycle("t3c");
        chk("t3c.icode_const", e_icode, 4'h6);
        chk("t3c.mem_const", applyMemFwd, 2'b01);
        chk("t3c.ex2_const", applyEx2Fwd, 1'b0);

        // 4: external stall over a load-use for 3 cycles with changing decode inputs
        setD(1'b1, 4'h5, RNONE, RNONE, RNONE, 4'h3);
        cycle("t4a");
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setD(1'b1, 4'h6, 4'h3, 4'($urandom_range(0, 2)), 4'h5, RNONE);
            cycle("t4s");
            chk("t4s.icode_const", e_icode, 4'h5);
            chk("t4s.lu_const", lu_count, 4'd1);
            chk("t4s.stall_const", d_stall, 1'b1);
        end

        // 5: flush coincident with load-use
        ext_stall = 1'b0;
        ext_flush = 1'b1;
        #1;
        chk("t5.stall_const", d_stall, 1'b0);
        cycle("t5");
        chk("t5.valid_const", e_valid, 1'b0);
        chk("t5.lu_const", lu_count, 4'd1);
        chk("t5.flags_const", {applyEx2Fwd, applyMemFwd}, 3'b000);
        ext_flush = 1'b0;

        // 6: saturate the counter, then reset asynchronously mid-stall
        for (int i = 0; i < CMAX + 1; i++) begin
            setD(1'b1, 4'hB, RNONE, RNONE, RNONE, 4'h3);
            cycle("t6l");
            setD(1'b1, 4'h6, 4'h3, 4'h1, 4'h1, RNONE);
            cycle("t6u");
        end
        chk("t6.sat_const", lu_count, 4'hF);
        setD(1'b1, 4'h5, RNONE, RNONE, RNONE, 4'h2);
        cycle("t6m");
        ext_stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("t6rst");
        chk("t6rst.lu_const", lu_count, 4'd0);
        chk("t6rst.valid_const", e_valid, 1'b0);
        ext_stall = 1'b0;
        #2;
        rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            setD(1'($urandom_range(0, 3) != 0), icodes[$urandom_range(0, 6)],
                 randReg(), randReg(), randReg(), randReg());
            ext_stall = ($urandom_range(0, 7) == 0);
            ext_flush = ($urandom_range(0, 7) == 0);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
